// File: rtl/fp_div_seq.sv
// Sequential FP16 divider: restoring division, one quotient bit per clock, start/done handshake.
// Optional macro STICKY_RNE_EN selects round-to-nearest-even with a sticky bit; default is round half up.
module fp_div_seq #(
    parameter int QBITS = 13
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] DIV_o
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_NORM, S_RND, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [15:0]        r_a, r_b, r_div;
    logic               r_sign;
    logic signed [7:0]  r_e;
    logic [10:0]        r_mB;
    logic [11:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic [3:0]         r_cnt;
    logic [9:0]         r_mant;
    logic               r_rbit, r_zero, r_ovf;
    logic [4:0]         r_efld;
`ifdef STICKY_RNE_EN
    logic               r_sticky;
`endif

    function automatic logic [3:0] f_lzc(input logic [10:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 11; i++)
            if (m[i]) n = 4'(10 - i);
        return n;
    endfunction

    // Operand unpacking and exponent setup, evaluated while in PREP
    logic [4:0]        w_expA, w_expB;
    logic [10:0]       w_mA_raw, w_mB_raw, w_mA, w_mB;
    logic [3:0]        w_lzA, w_lzB;
    logic signed [7:0] w_effA, w_effB, w_e;
    logic              w_inf, w_special;
    logic [15:0]       w_spec_res;

    always_comb begin
        w_expA     = r_a[14:10];
        w_expB     = r_b[14:10];
        w_mA_raw   = {|w_expA, r_a[9:0]};
        w_mB_raw   = {|w_expB, r_b[9:0]};
        w_lzA      = f_lzc(w_mA_raw);
        w_lzB      = f_lzc(w_mB_raw);
        w_mA       = w_mA_raw << w_lzA;
        w_mB       = w_mB_raw << w_lzB;
        w_effA     = (|w_expA) ? signed'({3'b0, w_expA}) : 8'sd1 - signed'({4'b0, w_lzA});
        w_effB     = (|w_expB) ? signed'({3'b0, w_expB}) : 8'sd1 - signed'({4'b0, w_lzB});
        w_e        = w_effA - w_effB + 8'sd15;
        w_inf      = (&w_expA) | (&w_expB) | (r_b[14:0] == 15'd0);
        w_special  = w_inf | (r_a[14:0] == 15'd0);
        w_spec_res = w_inf ? 16'h7C00 : {r_a[15] ^ r_b[15], 15'b0};
    end

    // One restoring step
    logic        w_ge;
    logic [11:0] w_diff;

    always_comb begin
        w_ge   = r_rem >= {1'b0, r_mB};
        w_diff = w_ge ? r_rem - {1'b0, r_mB} : r_rem;
    end

    // Normalisation, including the denormal right shift
    logic signed [7:0] w_e1, w_sh;
    logic [9:0]        w_m0, w_mant;
    logic              w_rb0, w_rbit, w_zero, w_ovf;
    logic [4:0]        w_efld;
    logic [11:0]       w_v, w_vs;
`ifdef STICKY_RNE_EN
    logic              w_lost;
`endif

    always_comb begin
        w_e1   = r_q[12] ? r_e : r_e - 8'sd1;
        w_m0   = r_q[12] ? r_q[11:2] : r_q[10:1];
        w_rb0  = r_q[12] ? r_q[1] : r_q[0];
        w_v    = {1'b1, w_m0, w_rb0};
        w_sh   = 8'sd1 - w_e1;
        w_vs   = '0;
        w_mant = w_m0;
        w_rbit = w_rb0;
        w_efld = w_e1[4:0];
        w_zero = 1'b0;
        w_ovf  = 1'b0;
`ifdef STICKY_RNE_EN
        w_lost = (r_q[12] & r_q[0]) | (r_rem != 12'd0);
`endif
        if (w_e1 >= 8'sd31) begin
            w_ovf = 1'b1;
        end else if (w_e1 <= 8'sd0) begin
            w_efld = 5'd0;
            if (w_sh > 8'sd11) begin
                w_zero = 1'b1;
            end else begin
                w_vs   = w_v >> w_sh[3:0];
                w_mant = w_vs[10:1];
                w_rbit = w_vs[0];
`ifdef STICKY_RNE_EN
                // Any bit dropped by the shift below the new round bit
                w_lost = w_lost | (|(w_v ^ (w_vs << w_sh[3:0])));
`endif
            end
        end
    end

    // Rounding; the 15-bit add lets mantissa carry ripple into the exponent field
    logic        w_inc;
    logic [14:0] w_sum;
    logic [15:0] w_rnd_res;

    always_comb begin
`ifdef STICKY_RNE_EN
        w_inc = r_rbit & (r_sticky | r_mant[0]);
`else
        w_inc = r_rbit;
`endif
        w_sum = {r_efld, r_mant} + 15'(w_inc);
        if (r_ovf)
            w_rnd_res = {r_sign, 5'h1F, 10'h0};
        else if (r_zero)
            w_rnd_res = {r_sign, 15'b0};
        else if (w_sum[14:10] == 5'h1F)
            w_rnd_res = {r_sign, 5'h1F, 10'h0};
        else
            w_rnd_res = {r_sign, w_sum};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_PREP;
            S_PREP: w_next = w_special ? S_DONE : S_DIV;
            S_DIV:  if (r_cnt == 4'(QBITS - 1)) w_next = S_NORM;
            S_NORM: w_next = S_RND;
            S_RND:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_div <= 16'h0000;
        else if (r_state == S_PREP && w_special)
            r_div <= w_spec_res;
        else if (r_state == S_RND)
            r_div <= w_rnd_res;
    end

    always_ff @(posedge clk_i) begin
        case (r_state)
            S_IDLE: if (start_i) begin
                r_a <= opA_i;
                r_b <= opB_i;
            end
            S_PREP: begin
                r_sign <= r_a[15] ^ r_b[15];
                r_e    <= w_e;
                r_mB   <= w_mB;
                r_rem  <= {1'b0, w_mA};
                r_q    <= '0;
                r_cnt  <= 4'd0;
            end
            S_DIV: begin
                r_rem <= w_diff << 1;
                r_q   <= {r_q[QBITS-2:0], w_ge};
                r_cnt <= r_cnt + 4'd1;
            end
            S_NORM: begin
                r_mant <= w_mant;
                r_rbit <= w_rbit;
                r_efld <= w_efld;
                r_zero <= w_zero;
                r_ovf  <= w_ovf;
`ifdef STICKY_RNE_EN
                r_sticky <= w_lost;
`endif
            end
            default: ;
        endcase
    end

    assign busy_o = (r_state == S_PREP) || (r_state == S_DIV) ||
                    (r_state == S_NORM) || (r_state == S_RND);
    assign done_o = (r_state == S_DONE);
    assign DIV_o  = r_div;

endmodule
